// File: rtl/packet_buffer_stream_reader_pkg.sv
// Shared packet buffer parameters for buffer clients.
// Sizes and latencies here must match the packet_buffer_ram_driver instance.
package packet_buffer_stream_reader_pkg;

    localparam int BYTE_LEN                   = 8;
    localparam int PACKET_BUFFER_SIZE         = 256;
    localparam int PACKET_BUFFER_READ_LATENCY = 2;
    localparam int PACKET_STREAM_FIFO_DEPTH   = 4;

    function automatic int clog2(input int value);
        return $clog2(value);
    endfunction

endpackage

// File: rtl/packet_buffer_stream_reader_stream_fifo.sv
// Parameterised synchronous FIFO with occupancy count.
// Push and pop may occur together, including while full.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Upstream credit accounting must make this unreachable.
    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && full && !do_pop));
    end

endmodule

// File: rtl/packet_buffer_stream_reader.sv
// Reads a byte range from the packet buffer and streams it out.
// Read requests are credit-limited so the skid FIFO never overflows.
module packet_buffer_stream_reader
    import packet_buffer_stream_reader_pkg::*;
#(
    parameter int RAM_SIZE     = PACKET_BUFFER_SIZE,
    parameter int READ_LATENCY = PACKET_BUFFER_READ_LATENCY,
    parameter int FIFO_DEPTH   = PACKET_STREAM_FIFO_DEPTH,
    localparam int AW = $clog2(RAM_SIZE),
    localparam int LW = AW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-1:0]       start_addr,
    input  logic [LW-1:0]       len,
    output logic                busy,
    output logic                done,
    output logic                read_req,
    output logic [AW-1:0]       read_addr,
    input  logic                read_ready,
    input  logic [BYTE_LEN-1:0] read_out,
    output logic                out_valid,
    output logic [BYTE_LEN-1:0] out_data,
    output logic                out_last,
    input  logic                out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least 1");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("READ_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] issue_addr;
    logic [LW-1:0] issue_rem;
    logic [LW-1:0] deliver_rem;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight_base;
    logic [CW-1:0] count_next;
    logic [CW:0]   occupancy;
    logic          fifo_empty;
    logic          fifo_full;
    logic          ret;
    logic          pop;
    logic          start_issue;
    logic          can_issue;
    logic          issue_now;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(RAM_SIZE - 1)) ? '0 : a + 1'b1;
    endfunction

    assign ret       = read_ready && (inflight != '0);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (deliver_rem == LW'(1));

    // Credit is judged on next-cycle occupancy so DEPTH=LATENCY+2 runs at full rate.
    assign inflight_base = inflight - CW'(ret);
    assign count_next    = fifo_count + CW'(ret) - CW'(pop);
    assign occupancy     = {1'b0, inflight_base} + {1'b0, count_next};

    assign start_issue = (state == IDLE) && start && (len != '0);
    assign can_issue   = (state == ISSUE) && (issue_rem != '0)
                       && (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign issue_now   = start_issue || can_issue;

    stream_fifo #(
        .WIDTH (BYTE_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret),
        .push_data (read_out),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            read_req    <= 1'b0;
            read_addr   <= '0;
            issue_addr  <= '0;
            issue_rem   <= '0;
            deliver_rem <= '0;
            inflight    <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= inflight_base + CW'(issue_now);
            if (pop) deliver_rem <= deliver_rem - 1'b1;
            unique case (state)
                IDLE: begin
                    read_req <= 1'b0;
                    if (start && len == '0) begin
                        done <= 1'b1;
                    end else if (start_issue) begin
                        busy        <= 1'b1;
                        read_req    <= 1'b1;
                        read_addr   <= start_addr;
                        issue_addr  <= addr_inc(start_addr);
                        issue_rem   <= len - 1'b1;
                        deliver_rem <= len;
                        state       <= (len == LW'(1)) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    read_req <= can_issue;
                    if (can_issue) begin
                        read_addr  <= issue_addr;
                        issue_addr <= addr_inc(issue_addr);
                        issue_rem  <= issue_rem - 1'b1;
                        if (issue_rem == LW'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    read_req <= 1'b0;
                    if (pop && deliver_rem == LW'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_buffer_stream_reader.sv
// Directed bench for packet_buffer_stream_reader with a latency-pipe
// model of the RAM driver.
module tb_packet_buffer_stream_reader;

    localparam int RS = 256;
    localparam int RL = 2;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] len;
    logic       busy;
    logic       done;
    logic       read_req;
    logic [7:0] read_addr;
    logic       read_ready;
    logic [7:0] read_out;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    logic [7:0]    mem [RS];
    logic [RL-1:0] vpipe;
    logic [7:0]    apipe [RL];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    packet_buffer_stream_reader #(
        .RAM_SIZE     (RS),
        .READ_LATENCY (RL),
        .FIFO_DEPTH   (FD)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .read_req   (read_req),
        .read_addr  (read_addr),
        .read_ready (read_ready),
        .read_out   (read_out),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    // Driver model: fixed latency, cleared by the shared reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe <= '0;
            for (int i = 0; i < RL; i++) apipe[i] <= '0;
        end else begin
            vpipe    <= {vpipe[RL-2:0], read_req};
            apipe[0] <= read_addr;
            for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
        end
    end

    assign read_ready = vpipe[RL-1];
    assign read_out   = mem[apipe[RL-1]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full-rate transfer; optional stray start pulse at cycle stray_at.
    task automatic run_full(input logic [7:0] addr, input int n,
                            input int stray_at);
        logic [7:0] ea;
        out_ready  = 1'b1;
        start      = 1'b1;
        start_addr = addr;
        len        = 9'(n);
        tick();
        start = 1'b0;
        for (int c = 1; c <= RL + 2 + n; c++) begin
            chk("read_req", read_req, (c <= n));
            if (c <= n) begin
                ea = addr + 8'(c - 1);
                chk("read_addr", read_addr, ea);
            end
            chk("out_valid", out_valid, (c >= RL + 2 && c <= RL + 1 + n));
            if (c >= RL + 2 && c <= RL + 1 + n) begin
                ea = addr + 8'(c - RL - 2);
                chk("out_data", out_data, mem[ea]);
                chk("out_last", out_last, (c == RL + 1 + n));
            end
            chk("done", done, (c == RL + 2 + n));
            chk("busy", busy, (c < RL + 2 + n));
            if (c == stray_at) begin
                start      = 1'b1;
                start_addr = 8'h80;
                len        = 9'd5;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("done_after", done, 1'b0);
        chk("valid_after", out_valid, 1'b0);
        chk("busy_after", busy, 1'b0);
    endtask

    initial begin
        int idx;
        int sum;
        bit fin;
        logic [15:0] pat;
        logic [7:0]  ea;

        for (int i = 0; i < RS; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 8; i++) mem[8'h10 + i] = 8'hA0 + 8'(i);
        mem[254] = 8'hF0;
        mem[255] = 8'hF1;
        mem[0]   = 8'hF2;
        mem[1]   = 8'hF3;

        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        out_ready  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_read_req", read_req, 1'b0);
        chk("rst_read_addr", read_addr, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        tick();

        // A0..A7 at 0x010, full rate
        run_full(8'h10, 8, 0);

        // wrap-around from RAM_SIZE-2
        run_full(8'hFE, 4, 0);

        // len 0: done pulse only
        start = 1'b1;
        start_addr = 8'h33;
        len = 9'd0;
        tick();
        start = 1'b0;
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b0);
        chk("len0_req", read_req, 1'b0);
        tick();
        chk("len0_done2", done, 1'b0);
        chk("len0_busy2", busy, 1'b0);
        chk("len0_req2", read_req, 1'b0);

        // start while busy is ignored
        run_full(8'h10, 8, 3);

        // backpressure: len 16 from 0x40
        out_ready  = 1'b0;
        start      = 1'b1;
        start_addr = 8'h40;
        len        = 9'd16;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            sum = int'(u_dut.inflight) + int'(u_dut.fifo_count);
            chk("credit_fill", (sum <= FD), 1'b1);
            tick();
        end
        chk("stall_req", read_req, 1'b0);
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_count", 32'(u_dut.fifo_count), FD);
        chk("stall_head", out_data, mem[8'h40]);
        pat = 16'b1001_1011_0100_1101;
        idx = 0;
        fin = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                sum = int'(u_dut.inflight) + int'(u_dut.fifo_count);
                chk("credit", (sum <= FD), 1'b1);
                if (u_dut.fifo_full) chk("full_stall", read_req, 1'b0);
                out_ready = pat[c % 16];
                if (out_valid && out_ready) begin
                    ea = 8'h40 + 8'(idx);
                    chk("bp_data", out_data, mem[ea]);
                    chk("bp_last", out_last, (idx == 15));
                    idx++;
                end
                tick();
            end
        end
        chk("bp_finished", fin, 1'b1);
        chk("bp_count", idx, 16);
        out_ready = 1'b1;
        tick();

        // reset at cycle 5 of a len-8 transfer
        start = 1'b1;
        start_addr = 8'h10;
        len = 9'd8;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("mid_busy", busy, 1'b1);
        chk("mid_valid", out_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_req", read_req, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_valid", out_valid, 1'b0);
            tick();
        end
        run_full(8'hFE, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
